hdb3_vb_insert: RTL and testbench
=================================

// Module: hdb3_vb_insert
// PURPOSE
//  HDB3 substitution stage feeding change_pole. Takes the NRZ serial stream and
//  emits a 2-bit code per bit: 00 = zero, 01 = mark, 10 = B, 11 = V.
//  - Inserts V on every run of N+1 consecutive zeros.
//  - Retro-fits B into the first zero of that run when needed.
//  - Uses an (N+1)-deep code delay line so the B can be written before it is output.
//  Output is directly wired to change_pole.data_in_b.
// PARAMETERS
//  N      3   HDB-N order; a V is placed on the (N+1)th consecutive zero; legal 2..7
// PORTS
//  clk          in   1  system clock, all state updates on rising edge
//  rst_n        in   1  reset, asynchronous, active-low (`RST_EN level)
//  data_en      in   1  1 = data_in valid this cycle; 0 = pipeline stalls
//  data_in      in   1  NRZ input bit, sampled when data_en=1
//  data_out_b   out  2  substituted code: 00 zero, 01 mark, 10 B, 11 V
//  data_out_vld out  1  1 when data_out_b holds a code derived from real input
// BEHAVIOUR
//  - Reset (async, rst_n low): all of the following are cleared immediately.
//    - Delay line codes and valid bits go to 0.
//    - zero_cnt = 0 and par = 0 (even).
//    - data_out_b = 2'b00 and data_out_vld = 0.
//    - Reset mid-run discards any partial zero run and all in-flight codes.
//  - All state advances only on edges with data_en=1. With data_en=0 every register
//    holds, including the outputs.
//  - Input coding, on an enabled edge:
//    - data_in=1 -> code 01; zero_cnt <= 0; par <= ~par.
//    - data_in=0 and zero_cnt < N -> code 00; zero_cnt <= zero_cnt + 1.
//    - data_in=0 and zero_cnt == N -> code 11 (V); zero_cnt <= 0; par <= 0.
//  - Delay line r[0..N], each entry {vld, code[1:0]}:
//    - r[0] <= new code, vld=1.
//    - r[i] <= r[i-1].
//    - data_out_b = r[N].code and data_out_vld = r[N].vld (registered outputs).
//  - B insertion, on the same edge a V enters r[0]:
//    - If par == 0 (even marks since last V or reset), r[N] is loaded with 10 instead
//      of r[N-1].code. That entry is the first zero of the run.
//    - If par == 1, r[N] gets r[N-1] unchanged (000V pattern).
//    - par counts marks only; B and V never toggle it.
//  - Latency: a bit sampled on enabled edge k appears on data_out_b after enabled
//    edge k+N. That is N+1 enabled edges from sampling to output, which is 4 for N=3.
//  - Back-to-back runs: 2(N+1) zeros give two independent substitutions. The second
//    always uses B because par=0 after the first V.
//  - Widths: zero_cnt is clog2(N+1) bits and never exceeds N.
//  - No overflow or underflow exists. data_out_vld rises after N+1 enabled edges
//    following reset.
// TESTING
//  - Reset, en=1, bits 0000 -> out 10,00,00,11 with vld high from the first code.
//  - Bits 1,0,0,0,0 (par odd) -> 01,00,00,00,11 with no B.
//  - Bits 1,1,0,0,0,0 (par even) -> 01,01,10,00,00,11.
//  - Eight zeros -> 10,00,00,11,10,00,00,11. Chained to change_pole, BP/BN alternate
//    correctly with V following the preceding polarity.
//  - Bits 0,0 then data_en=0 for 5 cycles, then 0,0 -> outputs and counters frozen
//    during the stall; result 10,00,00,11.
//  - rst_n low for 1 cycle after bits 0,0,0 -> vld=0 and out=00 at once; then 0000
//    yields 10,00,00,11 (no V from the stale run).

Source files
------------

// File: rtl/hdb3_vb_insert.sv
// hdb3_vb_insert
//   HDB3 substitution stage. Converts a serial NRZ stream into 2-bit codes
//   (00 zero, 01 mark, 10 B, 11 V). A V is placed on the (N+1)th consecutive
//   zero. When an even number of marks has been sent since the last V, the first
//   zero of that run is rewritten as B. The rewrite needs an (N+1)-deep code
//   delay line: the first zero is still in flight when its V is generated.
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_en      1 = data_in valid; 0 = every register holds
//   data_in      NRZ input bit
//   data_out_b   substituted code (feeds change_pole.data_in_b)
//   data_out_vld code on data_out_b was derived from real input
module hdb3_vb_insert #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_en,
  input  logic       data_in,
  output logic [1:0] data_out_b,
  output logic       data_out_vld
);

  localparam int CW = $clog2(N + 1);

  logic [N:0][1:0] code_pipe;
  logic [N:0]      vld_pipe;
  logic [CW-1:0]   zero_cnt;
  logic            par;        // 1 = odd number of marks since last V / reset

  logic [1:0]      new_code;
  logic            run_end;
  logic [CW-1:0]   zero_cnt_nxt;
  logic            par_nxt;

  always_comb begin
    new_code     = 2'b00;
    run_end      = 1'b0;
    zero_cnt_nxt = zero_cnt;
    par_nxt      = par;
    if (data_in) begin
      new_code     = 2'b01;
      zero_cnt_nxt = '0;
      par_nxt      = ~par;
    end else if (zero_cnt == CW'(N)) begin
      new_code     = 2'b11;
      run_end      = 1'b1;
      zero_cnt_nxt = '0;
      par_nxt      = 1'b0;
    end else begin
      zero_cnt_nxt = zero_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_pipe <= '0;
      vld_pipe  <= '0;
      zero_cnt  <= '0;
      par       <= 1'b0;
    end else if (data_en) begin
      code_pipe[0] <= new_code;
      for (int i = 1; i <= N; i++)
        code_pipe[i] <= code_pipe[i-1];
      vld_pipe <= {vld_pipe[N-1:0], 1'b1};
      zero_cnt <= zero_cnt_nxt;
      par      <= par_nxt;
      // On the edge the V enters, stage N-1 holds the first zero of the run;
      // with even parity it lands in the output stage as B instead.
      if (run_end && !par)
        code_pipe[N] <= 2'b10;
    end
  end

  assign data_out_b   = code_pipe[N];
  assign data_out_vld = vld_pipe[N];

endmodule

// File: tb/tb_hdb3_vb_insert.sv
module tb_hdb3_vb_insert;
  localparam int N = 3;

  logic       clk;
  logic       rst_n;
  logic       data_en;
  logic       data_in;
  logic [1:0] data_out_b;
  logic       data_out_vld;

  hdb3_vb_insert #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_en      (data_en),
    .data_in      (data_in),
    .data_out_b   (data_out_b),
    .data_out_vld (data_out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         sent   = 0;
  logic [1:0] last_exp = 2'b00;
  logic [1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Async reset asserted between edges, checked before any clock arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    data_en = 1'b0;
    #1;
    chk("rst_async_out", data_out_b, 2'b00);
    chk("rst_async_vld", {1'b0, data_out_vld}, 2'b00);
    exp_q.delete();
    sent = 0;
    last_exp = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_hold_vld", {1'b0, data_out_vld}, 2'b00);
  endtask

  task automatic send(input logic b, input logic [1:0] e);
    logic [1:0] got;
    data_en = 1'b1;
    data_in = b;
    exp_q.push_back(e);
    sent++;
    @(posedge clk); #1;
    data_en = 1'b0;
    chk("vld", {1'b0, data_out_vld}, {1'b0, sent >= N + 1});
    if (data_out_vld) begin
      if (exp_q.size() == 0) begin
        chk("q_empty", 2'b11, 2'b00);
      end else begin
        got = exp_q.pop_front();
        last_exp = got;
        chk("code", data_out_b, got);
      end
    end
  endtask

  // data_in wiggles during the stall; nothing may move.
  task automatic stall(input int n);
    data_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("stall_vld", {1'b0, data_out_vld}, {1'b0, sent >= N + 1});
      if (sent >= N + 1) chk("stall_code", data_out_b, last_exp);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) send(1'b1, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0; data_en = 1'b0; data_in = 1'b0;
    #12;

    // Four zeros from reset: even parity -> B00V
    do_reset();
    send(0, 2'b10); send(0, 2'b00); send(0, 2'b00); send(0, 2'b11);
    flush();

    // One mark then four zeros: odd parity -> 000V
    do_reset();
    send(1, 2'b01);
    send(0, 2'b00); send(0, 2'b00); send(0, 2'b00); send(0, 2'b11);
    flush();

    // Two marks then four zeros, stalled mid-run with valid output
    do_reset();
    send(1, 2'b01); send(1, 2'b01);
    send(0, 2'b10); send(0, 2'b00); send(0, 2'b00);
    stall(4);
    send(0, 2'b11);
    flush();

    // Eight zeros: two independent B00V substitutions
    do_reset();
    send(0, 2'b10); send(0, 2'b00); send(0, 2'b00); send(0, 2'b11);
    send(0, 2'b10); send(0, 2'b00); send(0, 2'b00); send(0, 2'b11);
    flush();

    // Stall before any valid output
    do_reset();
    send(0, 2'b10); send(0, 2'b00);
    stall(5);
    send(0, 2'b00); send(0, 2'b11);
    flush();

    // Reset mid-run with odd parity: stale run and parity must be discarded
    do_reset();
    send(1, 2'b01); send(1, 2'b01); send(1, 2'b01);
    send(0, 2'b00); send(0, 2'b00); send(0, 2'b00);
    do_reset();
    send(0, 2'b10); send(0, 2'b00); send(0, 2'b00); send(0, 2'b11);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
